// File: rtl/operand_sequencer.sv
// Button-driven operand entry sequencer: synchronise, debounce and edge-detect a push-button,
// then step through NUM_OPERANDS save strobes and a show-result strobe, with cancel/timeout abort.
module operand_sequencer #(
   parameter int NUM_OPERANDS    = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  button,
   input  logic                                  cancel,
   output logic [NUM_OPERANDS-1:0]               save_en,
   output logic                                  show_result,
   output logic                                  abort,
   output logic                                  busy,
   output logic [$clog2(NUM_OPERANDS+1)-1:0]     operand_idx
);

   // state       | meaning
   // IDLE        | no sequence in progress, waiting for first press
   // COLLECT     | saving operands, operand_idx is the next one to save
   // WAIT_RESULT | all operands saved, next press shows the result

   localparam int IW = $clog2(NUM_OPERANDS + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, WAIT_RESULT} state_t;

   state_t          state;
   logic            sync_1;
   logic            sync_2;
   logic            db_level;
   logic [DW-1:0]   db_cnt;
   logic [TW-1:0]   to_cnt;
   logic            db_flip;
   logic            press;
   logic            timeout_hit;

   // The press is taken on the same edge the debounced level flips high,
   // so the FSM strobe lands in the cycle after that edge.
   assign db_flip     = (sync_2 != db_level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
   assign press       = db_flip && sync_2;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync_1 <= button;
         sync_2 <= sync_1;
         if (db_flip) begin
            db_level <= sync_2;
            db_cnt   <= '0;
         end else if (sync_2 != db_level) begin
            db_cnt <= db_cnt + DW'(1);
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         save_en     <= '0;
         show_result <= 1'b0;
         abort       <= 1'b0;
         busy        <= 1'b0;
         operand_idx <= '0;
         to_cnt      <= '0;
      end else begin
         save_en     <= '0;
         show_result <= 1'b0;
         abort       <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (press) begin
                  save_en     <= NUM_OPERANDS'(1);
                  operand_idx <= IW'(1);
                  busy        <= 1'b1;
                  state       <= (NUM_OPERANDS == 1) ? WAIT_RESULT : COLLECT;
               end
            end
            COLLECT, WAIT_RESULT: begin
               if (cancel) begin
                  abort       <= 1'b1;
                  busy        <= 1'b0;
                  operand_idx <= '0;
                  to_cnt      <= '0;
                  state       <= IDLE;
               end else if (press) begin
                  to_cnt <= '0;
                  if (state == WAIT_RESULT) begin
                     show_result <= 1'b1;
                     busy        <= 1'b0;
                     operand_idx <= '0;
                     state       <= IDLE;
                  end else begin
                     save_en     <= NUM_OPERANDS'(1) << operand_idx;
                     operand_idx <= operand_idx + IW'(1);
                     if (operand_idx == IW'(NUM_OPERANDS - 1))
                        state <= WAIT_RESULT;
                  end
               end else if (timeout_hit) begin
                  abort       <= 1'b1;
                  busy        <= 1'b0;
                  operand_idx <= '0;
                  to_cnt      <= '0;
                  state       <= IDLE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            default: begin
               busy        <= 1'b0;
               operand_idx <= '0;
               to_cnt      <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: two configurations checked every cycle against a
// behavioural model, plus directed latency / priority / timeout / reset checks.
module tb_operand_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, btn_a, cxl_a, rst_b, btn_b, cxl_b;
   logic [2:0] save_a;
   logic       show_a, abort_a, busy_a;
   logic [1:0] idx_a;
   logic [0:0] save_b;
   logic       show_b, abort_b, busy_b;
   logic [0:0] idx_b;

   operand_sequencer #(.NUM_OPERANDS(3), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_a (
      .clk(clk), .rst_n(rst_a), .button(btn_a), .cancel(cxl_a),
      .save_en(save_a), .show_result(show_a), .abort(abort_a), .busy(busy_a), .operand_idx(idx_a));

   operand_sequencer #(.NUM_OPERANDS(1), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_b), .button(btn_b), .cancel(cxl_b),
      .save_en(save_b), .show_result(show_b), .abort(abort_b), .busy(busy_b), .operand_idx(idx_b));

   typedef struct {
      logic       s1, s2, db;
      int         run;
      logic       active;
      int         taken;
      int         idle;
      logic [7:0] exp;
   } model_t;

   model_t m[2];
   int n_checks = 0;
   int n_err    = 0;

   function automatic logic [7:0] pk(input int save, input bit show, input bit ab,
                                     input bit bsy, input int idx);
      return {3'(save), show, ab, bsy, 2'(idx)};
   endfunction

   function automatic logic [7:0] obs(input int k);
      if (k == 0) return {save_a, show_a, abort_a, busy_a, idx_a};
      return {2'b00, save_b, show_b, abort_b, busy_b, 1'b0, idx_b};
   endfunction

   task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
      n_checks++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model_reset(input int k);
      m[k].s1 = 0; m[k].s2 = 0; m[k].db = 0; m[k].run = 0;
      m[k].active = 0; m[k].taken = 0; m[k].idle = 0; m[k].exp = '0;
   endtask

   // One clock edge of the behaviour: button delayed two samples, level accepted after
   // d consecutive differing samples, then a count of saved operands drives the strobes.
   task automatic model_edge(input int k, input int n, input int d, input int t,
                             input logic rst, input logic btn, input logic cxl);
      bit flip, pr, show, ab;
      int save;
      if (!rst) begin
         model_reset(k);
      end else begin
         flip = (m[k].s2 != m[k].db) && (m[k].run + 1 >= d);
         pr   = flip && m[k].s2;
         if (flip) begin
            m[k].db = m[k].s2; m[k].run = 0;
         end else if (m[k].s2 != m[k].db) m[k].run++;
         else m[k].run = 0;
         m[k].s2 = m[k].s1;
         m[k].s1 = btn;
         save = 0; show = 0; ab = 0;
         if (!m[k].active) begin
            if (pr) begin
               save = 1; m[k].taken = 1; m[k].active = 1;
            end
            m[k].idle = 0;
         end else if (cxl) begin
            ab = 1; m[k].active = 0; m[k].taken = 0; m[k].idle = 0;
         end else if (pr) begin
            if (m[k].taken == n) begin
               show = 1; m[k].active = 0; m[k].taken = 0;
            end else begin
               save = 1 << m[k].taken; m[k].taken++;
            end
            m[k].idle = 0;
         end else if (t > 0 && m[k].idle == t) begin
            ab = 1; m[k].active = 0; m[k].taken = 0; m[k].idle = 0;
         end else begin
            m[k].idle++;
         end
         m[k].exp = pk(save, show, ab, m[k].active, m[k].taken);
      end
   endtask

   task automatic step;
      @(posedge clk);
      model_edge(0, 3, 4, 20, rst_a, btn_a, cxl_a);
      model_edge(1, 1, 4, 0, rst_b, btn_b, cxl_b);
      #1;
      check("cyc_a", obs(0), m[0].exp);
      check("cyc_b", obs(1), m[1].exp);
   endtask

   task automatic set_btn(input int k, input logic v);
      if (k == 0) btn_a = v; else btn_b = v;
   endtask

   // Press held 10 cycles then released 8; strobe expected on the 6th edge.
   task automatic press_chk(input int k, input logic [7:0] e, input string tag);
      set_btn(k, 1'b1);
      repeat (5) step;
      step;
      check(tag, obs(k), e);
      repeat (4) step;
      set_btn(k, 1'b0);
      repeat (8) step;
   endtask

   int n_bounce;
   int n_ab;
   int hold;

   initial begin
      rst_a = 0; btn_a = 0; cxl_a = 0;
      rst_b = 0; btn_b = 0; cxl_b = 0;
      model_reset(0);
      model_reset(1);
      #2;
      repeat (3) step;
      check("rst_a", obs(0), 8'h00);
      check("rst_b", obs(1), 8'h00);
      rst_a = 1; rst_b = 1;
      repeat (2) step;

      press_chk(0, pk(1, 0, 0, 1, 1), "clean_p0");
      press_chk(0, pk(2, 0, 0, 1, 2), "clean_p1");
      press_chk(0, pk(4, 0, 0, 1, 3), "clean_p2");
      press_chk(0, pk(0, 1, 0, 0, 0), "clean_show");

      n_bounce = 0;
      for (int i = 0; i < 12; i++) begin
         btn_a = ((i / 2) % 2 == 0);
         step;
         if (save_a != 0) n_bounce++;
      end
      btn_a = 1;
      repeat (5) begin
         step;
         if (save_a != 0) n_bounce++;
      end
      check("bounce_quiet", 8'(n_bounce), 8'd0);
      step;
      check("bounce_press", obs(0), pk(1, 0, 0, 1, 1));
      repeat (4) step;
      btn_a = 0;
      repeat (16) step;
      step;
      check("timeout", obs(0), pk(0, 0, 1, 0, 0));

      press_chk(0, pk(1, 0, 0, 1, 1), "after_to");
      press_chk(0, pk(2, 0, 0, 1, 2), "wr_p1");
      press_chk(0, pk(4, 0, 0, 1, 3), "wr_p2");
      cxl_a = 1;
      step;
      check("cxl_wait", obs(0), pk(0, 0, 1, 0, 0));
      step;
      check("cxl_idle", obs(0), pk(0, 0, 0, 0, 0));
      cxl_a = 0;

      press_chk(0, pk(1, 0, 0, 1, 1), "pre_cc");
      btn_a = 1;
      repeat (5) step;
      cxl_a = 1;
      step;
      check("press_cancel", obs(0), pk(0, 0, 1, 0, 0));
      cxl_a = 0;
      repeat (4) step;
      btn_a = 0;
      repeat (8) step;

      press_chk(0, pk(1, 0, 0, 1, 1), "pre_ct");
      repeat (3) step;
      btn_a = 1;
      repeat (5) step;
      step;
      check("press_timeout", obs(0), pk(2, 0, 0, 1, 2));
      repeat (4) step;
      btn_a = 0;
      repeat (8) step;
      cxl_a = 1;
      step;
      cxl_a = 0;

      for (int s = 0; s < 60; s++) begin
         btn_a = 1'($urandom_range(0, 1));
         hold  = $urandom_range(1, 12);
         repeat (hold) begin
            cxl_a = ($urandom_range(0, 15) == 0);
            step;
         end
      end
      cxl_a = 0;
      btn_a = 0;
      repeat (10) step;

      press_chk(1, pk(1, 0, 0, 1, 1), "b_p0");
      n_ab = 0;
      repeat (1000) begin
         step;
         if (abort_b) n_ab++;
      end
      check("b_no_timeout", 8'(n_ab), 8'd0);
      press_chk(1, pk(0, 1, 0, 0, 0), "b_show");
      press_chk(1, pk(1, 0, 0, 1, 1), "b_p1");
      btn_b = 1;
      repeat (3) step;
      rst_b = 0;
      #1;
      model_reset(1);
      check("b_rst_async", obs(1), 8'h00);
      repeat (3) step;
      rst_b = 1;
      repeat (5) step;
      step;
      check("b_rst_held", obs(1), pk(1, 0, 0, 1, 1));
      repeat (4) step;
      btn_b = 0;
      repeat (8) step;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
